// File: rtl/iomem_timer.sv
// iomem_timer: memory-mapped down-counting timer on the picosoc iomem bus
//   clk, rst     system clock, synchronous active-high reset
//   iomem_valid  bus request valid
//   iomem_ready  single-cycle acknowledge, one cycle after a request in the window
//   iomem_wstrb  byte write strobes, 0 = read
//   iomem_addr   byte address, window decoded on [31:8]
//   iomem_wdata  write data
//   iomem_rdata  read data, valid only while iomem_ready, else 0
//   irq          level interrupt, STAT.pend & CTRL.ie
module iomem_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
    parameter int          PRESC_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        irq
);
    logic               en, ar, ie, pend;
    logic [PRESC_W-1:0] presc, pcnt;
    logic [31:0]        load, count, mask, load_new, rd;
    logic [7:0]         off;
    logic               sel, ack, wr, ctrl_wr, presc_wr, load_wr, stat_wr, tick, step, expire;
    always_comb begin
        off      = iomem_addr[7:0];
        sel      = iomem_valid && iomem_addr[31:8] == BASE_ADDR[31:8];
        ack      = sel && !iomem_ready;
        wr       = ack && |iomem_wstrb;
        ctrl_wr  = wr && off == 8'h00;
        presc_wr = wr && off == 8'h04;
        load_wr  = wr && off == 8'h08;
        stat_wr  = wr && off == 8'h10;
        mask     = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}}, {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
        load_new = (load & ~mask) | (iomem_wdata & mask);
        tick     = en && pcnt == presc;
        // a LOAD write, or a CTRL write that clears en, swallows a coincident tick
        step     = tick && !load_wr && !(ctrl_wr && iomem_wstrb[0] && !iomem_wdata[0]);
        expire   = step && count == 32'd0;
        rd       = off == 8'h00 ? {29'd0, ie, ar, en} :
                   off == 8'h04 ? 32'(presc) :
                   off == 8'h08 ? load :
                   off == 8'h0C ? count :
                   off == 8'h10 ? {31'd0, pend} : 32'd0;
        irq      = pend && ie;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
            en          <= 1'b0;
            ar          <= 1'b0;
            ie          <= 1'b0;
            pend        <= 1'b0;
            presc       <= '0;
            pcnt        <= '0;
            load        <= '0;
            count       <= '0;
        end else begin
            iomem_ready <= ack;
            iomem_rdata <= ack ? rd : 32'd0;
            pcnt        <= (!en || tick) ? '0 : pcnt + 1'b1;
            if (step) begin
                if (count != 32'd0)
                    count <= count - 32'd1;
                else if (ar)
                    count <= load;
                else
                    en <= 1'b0;
            end
            if (expire)
                pend <= 1'b1;
            else if (stat_wr && iomem_wstrb[0] && iomem_wdata[0])
                pend <= 1'b0;
            if (ctrl_wr && iomem_wstrb[0])
                {ie, ar, en} <= iomem_wdata[2:0];
            if (presc_wr)
                presc <= (presc & ~mask[PRESC_W-1:0]) | (iomem_wdata[PRESC_W-1:0] & mask[PRESC_W-1:0]);
            if (load_wr) begin
                load  <= load_new;
                count <= load_new;
                pcnt  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_iomem_timer.sv
// tb_iomem_timer: directed bench with a per-cycle reference model of the timer peripheral
module tb_iomem_timer;
    logic        clk = 1'b0, rst = 1'b1, valid = 1'b0, ready, irq;
    logic [3:0]  wstrb = 4'h0;
    logic [31:0] addr = '0, wdata = '0, rdata, q;
    int          vectors = 0, errs = 0, n;

    localparam logic [31:0] CTRL = 32'h0300_0000, PRESC = 32'h0300_0004, LOAD = 32'h0300_0008,
                            COUNT = 32'h0300_000C, STAT = 32'h0300_0010;

    always #5 clk = ~clk;

    iomem_timer dut (
        .clk(clk), .rst(rst), .iomem_valid(valid), .iomem_ready(ready), .iomem_wstrb(wstrb),
        .iomem_addr(addr), .iomem_wdata(wdata), .iomem_rdata(rdata), .irq(irq)
    );

    // reference model: prescaler tracked as clocks remaining until the next tick
    logic        m_en = 0, m_ar = 0, m_ie = 0, m_pend = 0, m_ready = 0;
    logic [15:0] m_presc = 0, m_left = 0;
    logic [31:0] m_load = 0, m_count = 0, m_rdata = 0;

    always @(posedge clk) begin : model
        logic        hit, ack, wr, tick, blk, fired;
        logic [31:0] msk, rv;
        if (rst) begin
            m_en = 0; m_ar = 0; m_ie = 0; m_pend = 0; m_ready = 0;
            m_presc = 0; m_left = 0; m_load = 0; m_count = 0; m_rdata = 0;
        end else begin
            hit = valid && addr[31:8] == 24'h030000;
            ack = hit && !m_ready;
            wr  = ack && wstrb != 4'h0;
            msk = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
            case (addr[7:0])
                8'h00:   rv = {29'd0, m_ie, m_ar, m_en};
                8'h04:   rv = {16'd0, m_presc};
                8'h08:   rv = m_load;
                8'h0C:   rv = m_count;
                8'h10:   rv = {31'd0, m_pend};
                default: rv = 0;
            endcase
            tick  = m_en && m_left == 0;
            blk   = wr && (addr[7:0] == 8'h08 || (addr[7:0] == 8'h00 && wstrb[0] && !wdata[0]));
            fired = 0;
            if (m_en) m_left = tick ? m_presc : m_left - 16'd1;
            if (tick && !blk) begin
                if (m_count == 0) begin
                    fired  = 1;
                    m_pend = 1;
                    if (m_ar) m_count = m_load; else m_en = 0;
                end else m_count = m_count - 1;
            end
            if (wr) begin
                case (addr[7:0])
                    8'h00: if (wstrb[0]) {m_ie, m_ar, m_en} = wdata[2:0];
                    8'h04: m_presc = (m_presc & ~msk[15:0]) | (wdata[15:0] & msk[15:0]);
                    8'h08: begin
                        m_load  = (m_load & ~msk) | (wdata & msk);
                        m_count = m_load;
                        m_left  = m_presc;
                    end
                    8'h10: if (wstrb[0] && wdata[0] && !fired) m_pend = 0;
                    default: ;
                endcase
            end
            if (!m_en) m_left = m_presc;
            m_ready = ack;
            m_rdata = ack ? rv : 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("ready", {31'd0, ready}, {31'd0, m_ready});
        chk("rdata", rdata, m_rdata);
        chk("irq", {31'd0, irq}, {31'd0, m_ie & m_pend});
    end

    task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, output logic [31:0] r);
        int k;
        @(negedge clk);
        addr = a; wstrb = s; wdata = d; valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!ready && k < 8) begin
            @(negedge clk);
            k++;
        end
        if (!ready) chk("bus_timeout", {31'd0, ready}, 32'd1);
        r = rdata;
        valid = 1'b0; wstrb = 4'h0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        bus(a, 4'hF, d, r);
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        bus(a, 4'h0, 32'd0, r);
        chk(name, r, exp);
    endtask

    initial begin
        // reset
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;
        rd("rst_ctrl", CTRL, 0);
        rd("rst_load", LOAD, 0);
        rd("rst_count", COUNT, 0);
        rd("rst_stat", STAT, 0);

        // handshake: ready pulses every other cycle while valid is held
        wr(LOAD, 32'h1234_5678);
        @(negedge clk);
        addr = LOAD; wstrb = 4'h0; valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("hs_ready", {31'd0, ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            chk("hs_rdata", rdata, (i % 2 == 1) ? 32'h1234_5678 : 32'd0);
        end
        addr = 32'h0400_0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("oow_ready", {31'd0, ready}, 32'd0);
        end
        valid = 1'b0;

        // one-shot: (5+1)*(3+1) clocks to expiry
        wr(PRESC, 3);
        wr(LOAD, 5);
        wr(CTRL, 5);
        n = 0;
        while (!irq && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("oneshot_clocks", n, 24);
        rd("oneshot_ctrl", CTRL, 4);
        rd("oneshot_count", COUNT, 0);
        rd("oneshot_stat", STAT, 1);
        wr(STAT, 1);
        chk("stat_clear_irq", {31'd0, irq}, 32'd0);

        // auto-reload: expiry every 3 clocks; W1C landing on an expiry edge loses
        wr(CTRL, 0);
        wr(PRESC, 0);
        wr(LOAD, 2);
        wr(CTRL, 7);
        repeat (4) @(negedge clk);
        bus(STAT, 4'h1, 32'd1, q);
        chk("w1c_vs_expiry_irq", {31'd0, irq}, 32'd1);
        rd("ar_stat", STAT, 1);
        wr(CTRL, 3);
        chk("ie_off_irq", {31'd0, irq}, 32'd0);
        rd("ie_off_stat", STAT, 1);
        wr(CTRL, 0);
        wr(STAT, 1);
        rd("ar_stat_cleared", STAT, 0);

        // byte strobes
        wr(LOAD, 0);
        bus(LOAD, 4'b0010, 32'hAABB_CCDD, q);
        rd("strb_load", LOAD, 32'h0000_CC00);
        rd("strb_count", COUNT, 32'h0000_CC00);
        wr(COUNT, 32'hFFFF_FFFF);
        rd("count_ro", COUNT, 32'h0000_CC00);
        rd("hole_read", 32'h0300_0020, 0);

        // reset mid-count
        wr(PRESC, 9);
        wr(LOAD, 5);
        wr(CTRL, 5);
        repeat (21) @(negedge clk);
        rd("midcount", COUNT, 3);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd("post_rst_ctrl", CTRL, 0);
        rd("post_rst_presc", PRESC, 0);
        rd("post_rst_load", LOAD, 0);
        rd("post_rst_count", COUNT, 0);
        rd("post_rst_stat", STAT, 0);
        repeat (100) @(negedge clk);
        chk("post_rst_irq", {31'd0, irq}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
